// File: rtl/console_pkg.sv
// console_pkg: shared constants and types for the console UART transmitter
package console_pkg;
    localparam logic [15:0] DATA_ADDR_DEF = 16'hFFFF;
    localparam logic [15:0] STAT_ADDR_DEF = 16'hFFFD;
    localparam int ST_NOTFULL = 0;
    localparam int ST_IDLE    = 1;
    localparam int ST_OVF     = 2;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 frame generator pulling bytes through a valid/ready handshake
module uart_tx_serializer
    import console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       active
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    ser_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] sh;
    logic done;
    assign done = cnt == '0;
    assign ready = state == S_IDLE || (state == S_STOP && done);
    assign active = state != S_IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            tx <= 1'b1;
            cnt <= RELOAD;
            idx <= '0;
            sh <= '0;
        end else begin
            cnt <= (state == S_IDLE || done) ? RELOAD : cnt - 1'b1;
            case (state)
                S_IDLE: if (valid) begin
                    sh <= data;
                    tx <= 1'b0;
                    state <= S_START;
                end
                S_START: if (done) begin
                    tx <= sh[0];
                    idx <= '0;
                    state <= S_DATA;
                end
                // shift so sh[0] always holds the bit currently on the line
                S_DATA: if (done) begin
                    sh <= sh >> 1;
                    tx <= (idx == 3'd7) ? 1'b1 : sh[1];
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) state <= S_STOP;
                end
                S_STOP: if (done) begin
                    if (valid) begin
                        sh <= data;
                        tx <= 1'b0;
                        state <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/console_uart_tx.sv
// console_uart_tx: Z80 bus console mailbox with FIFO feeding an 8N1 serialiser
module console_uart_tx
    import console_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 217,
    parameter int          FIFO_AW      = 4,
    parameter logic [15:0] DATA_ADDR    = DATA_ADDR_DEF,
    parameter logic [15:0] STAT_ADDR    = STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    input  logic        bus_rd,
    output logic [7:0]  bus_rdata,
    output logic        bus_hit,
    output logic        tx,
    output logic        tx_busy
);
    localparam int DEPTH = 2 ** FIFO_AW;
    logic [7:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0] count;
    logic wr_q, overflow;
    logic [7:0] last_char, status;
    logic wr_ev, push_ev, clr_ev, full, empty, push, pop, ser_ready, ser_active;
    logic is_data, is_stat;
    assign is_data = bus_addr == DATA_ADDR;
    assign is_stat = bus_addr == STAT_ADDR;
    assign wr_ev = bus_wr & ~wr_q;
    assign push_ev = wr_ev & is_data;
    assign clr_ev = wr_ev & is_stat;
    assign full = count == (FIFO_AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign pop = ser_ready & ~empty;
    // a full FIFO still accepts when the same cycle frees a slot
    assign push = push_ev & (~full | pop);
    assign status = {5'b0, overflow, empty & ~ser_active, ~full};
    assign bus_hit = (bus_rd | bus_wr) & (is_data | is_stat);
    assign bus_rdata = (bus_rd & bus_hit) ? (is_data ? last_char : status) : 8'h00;
    assign tx_busy = ~empty | ser_active;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= 1'b0;
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            last_char <= '0;
        end else begin
            wr_q <= bus_wr;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
            if (push_ev) last_char <= bus_wdata;
            if (push_ev & ~push) overflow <= 1'b1;
            else if (clr_ev) overflow <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus_wdata;
    end
    uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk(clk),
        .reset(reset),
        .data(mem[rptr]),
        .valid(~empty),
        .ready(ser_ready),
        .tx(tx),
        .active(ser_active)
    );
endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: directed bench for console_uart_tx at 4 clocks/bit, 4-entry FIFO
module tb_console_uart_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] bus_addr = '0;
    logic [7:0] bus_wdata = '0;
    logic bus_wr = 1'b0, bus_rd = 1'b0;
    logic [7:0] bus_rdata;
    logic bus_hit, tx, tx_busy;
    int errors = 0, checks = 0;
    logic txlog [0:8191];
    int ncyc = 0;
    int t0;
    logic [7:0] bytes [6];

    console_uart_tx #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata), .bus_hit(bus_hit),
        .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // one tx sample per cycle, taken mid-cycle
    always @(negedge clk) begin
        txlog[ncyc] = tx;
        ncyc = ncyc + 1;
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(logic [15:0] a, logic [7:0] d);
        bus_addr = a;
        bus_wdata = d;
        bus_wr = 1'b1;
        cyc();
        bus_wr = 1'b0;
        cyc();
    endtask

    task automatic rd_chk(string tag, logic [15:0] a, logic [7:0] exp);
        bus_addr = a;
        bus_rd = 1'b1;
        #1;
        chk({tag, "_hit"}, 32'(bus_hit), 32'd1);
        chk(tag, 32'(bus_rdata), 32'(exp));
        bus_rd = 1'b0;
    endtask

    // each bit period's four samples must all equal the expected line level
    task automatic chk_frames(string tag, int start, int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 10; i++) begin
                logic bitv;
                logic [3:0] obs;
                int s;
                bitv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : bytes[k][i-1];
                s = start + 40 * k + 4 * i;
                obs = {txlog[s+3], txlog[s+2], txlog[s+1], txlog[s]};
                chk($sformatf("%s_f%0d_b%0d", tag, k, i), 32'(obs), {28'b0, {4{bitv}}});
            end
    endtask

    task automatic chk_high(string tag, int from, int to);
        int z = 0;
        for (int i = from; i < to; i++) if (txlog[i] !== 1'b1) z++;
        chk(tag, z, 0);
    endtask

    initial begin
        cyc(3);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        cyc();
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(tx_busy), 32'd0);
        rd_chk("rst_status", 16'hFFFD, 8'h03);
        rd_chk("rst_last", 16'hFFFF, 8'h00);

        // single write with bus_wr held for three cycles
        t0 = ncyc;
        bus_addr = 16'hFFFF;
        bus_wdata = 8'h55;
        bus_wr = 1'b1;
        cyc();
        chk("w1_busy", 32'(tx_busy), 32'd1);
        chk("w1_tx_pre", 32'(tx), 32'd1);
        cyc(2);
        bus_wr = 1'b0;
        cyc(45);
        bytes[0] = 8'h55;
        chk("w1_pre", 32'(txlog[t0+1]), 32'd1);
        chk_frames("w1", t0 + 2, 1);
        chk_high("w1_after", t0 + 42, t0 + 47);
        chk("w1_busy_end", 32'(tx_busy), 32'd0);
        rd_chk("w1_last", 16'hFFFF, 8'h55);

        // five back-to-back writes: four queued, one in flight
        t0 = ncyc;
        for (int k = 0; k < 5; k++) begin
            bytes[k] = 8'h41 + 8'(k);
            wr(16'hFFFF, bytes[k]);
        end
        rd_chk("w5_full_status", 16'hFFFD, 8'h00);
        cyc(205);
        chk_frames("w5", t0 + 2, 5);
        chk_high("w5_after", t0 + 202, t0 + 212);
        rd_chk("w5_end_status", 16'hFFFD, 8'h03);

        // six writes overflow the FIFO, STAT write clears overflow
        t0 = ncyc;
        for (int k = 0; k < 6; k++) begin
            bytes[k] = 8'h61 + 8'(k);
            wr(16'hFFFF, bytes[k]);
        end
        rd_chk("ovf_status", 16'hFFFD, 8'h04);
        rd_chk("ovf_last", 16'hFFFF, 8'h66);
        wr(16'hFFFD, 8'hA5);
        rd_chk("ovf_clr_status", 16'hFFFD, 8'h00);
        cyc(205);
        chk_frames("ovf", t0 + 2, 5);
        chk_high("ovf_after", t0 + 202, t0 + 216);
        rd_chk("ovf_end_status", 16'hFFFD, 8'h03);

        // reset during data bit 3 of 0xA5 with another byte queued
        t0 = ncyc;
        wr(16'hFFFF, 8'hA5);
        wr(16'hFFFF, 8'h3C);
        cyc(15);
        chk("mid_bit3", 32'(tx), 32'd0);
        chk("mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        cyc();
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        cyc(50);
        chk_high("mid_after", t0 + 20, t0 + 69);
        chk("mid_busy_end", 32'(tx_busy), 32'd0);
        rd_chk("mid_status", 16'hFFFD, 8'h03);

        // accesses outside the decoded addresses
        t0 = ncyc;
        bus_addr = 16'hFFFE;
        bus_wdata = 8'h77;
        bus_wr = 1'b1;
        #1;
        chk("miss_fffe_hit", 32'(bus_hit), 32'd0);
        cyc();
        bus_wr = 1'b0;
        cyc();
        bus_addr = 16'h1000;
        bus_wr = 1'b1;
        bus_rd = 1'b1;
        #1;
        chk("miss_1000_hit", 32'(bus_hit), 32'd0);
        chk("miss_1000_rdata", 32'(bus_rdata), 32'd0);
        cyc();
        bus_wr = 1'b0;
        bus_rd = 1'b0;
        cyc(10);
        chk_high("miss_tx", t0, t0 + 11);
        chk("miss_busy", 32'(tx_busy), 32'd0);
        rd_chk("miss_status", 16'hFFFD, 8'h03);
        rd_chk("miss_last", 16'hFFFF, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
